// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration when both sides are pending.
module mem_port_arbiter #(
   parameter int TIMEOUT = 64,
   parameter int ADDR_W  = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              IReq,
   input  logic [ADDR_W-1:0] IAddr,
   output logic              IReady,
   output logic              IDataReady,
   output logic [31:0]       IData,
   input  logic              DReq,
   input  logic              DWe,
   input  logic [ADDR_W-1:0] DAddr,
   input  logic [31:0]       DWData,
   input  logic [3:0]        DBe,
   output logic              DReady,
   output logic              DDataReady,
   output logic [31:0]       DRData,
   output logic              MemExecute,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [31:0]       MemWData,
   output logic [3:0]        MemBe,
   input  logic              MemReady,
   input  logic              MemDataReady,
   input  logic [31:0]       MemRData,
   output logic [1:0]        Grant,
   output logic              Err,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_RD_WAIT = 2'd2;

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   // Read completes on the edge where the wait counter would reach TIMEOUT-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

   logic [1:0]        state;
   logic              i_pending;
   logic              d_pending;
   logic [ADDR_W-1:0] i_addr_q;
   logic [ADDR_W-1:0] d_addr_q;
   logic              d_we_q;
   logic [31:0]       d_wdata_q;
   logic [3:0]        d_be_q;
   logic [CNT_W-1:0]  cnt;

   logic              i_cand;
   logic              d_cand;
   logic              pick_d;
   logic              rd_finish;
   logic [ADDR_W-1:0] i_addr_sel;
   logic [ADDR_W-1:0] d_addr_sel;
   logic              d_we_sel;
   logic [31:0]       d_wdata_sel;
   logic [3:0]        d_be_sel;
   logic [31:0]       rd_data;

`ifdef MEM_ARB_RR_EN
   logic              last_d;
`endif

   assign IReady    = ~i_pending;
   assign DReady    = ~d_pending;
   assign dbg_state = state;

   // A request pulse bypasses the pending latch so an idle port issues next cycle.
   always_comb begin
      i_cand      = i_pending | IReq;
      d_cand      = d_pending | DReq;
      i_addr_sel  = i_pending ? i_addr_q  : IAddr;
      d_addr_sel  = d_pending ? d_addr_q  : DAddr;
      d_we_sel    = d_pending ? d_we_q    : DWe;
      d_wdata_sel = d_pending ? d_wdata_q : DWData;
      d_be_sel    = d_pending ? d_be_q    : DBe;
`ifdef MEM_ARB_RR_EN
      pick_d      = d_cand & (~i_cand | ~last_d);
`else
      pick_d      = d_cand;
`endif
      rd_finish   = (state == ST_RD_WAIT) && (MemDataReady || (cnt == CNT_LAST));
      rd_data     = MemDataReady ? MemRData : 32'h0000_0000;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= ST_IDLE;
         i_pending  <= 1'b0;
         d_pending  <= 1'b0;
         i_addr_q   <= '0;
         d_addr_q   <= '0;
         d_we_q     <= 1'b0;
         d_wdata_q  <= '0;
         d_be_q     <= '0;
         cnt        <= '0;
         MemExecute <= 1'b0;
         MemWe      <= 1'b0;
         MemAddr    <= '0;
         MemWData   <= '0;
         MemBe      <= '0;
         Grant      <= '0;
         IDataReady <= 1'b0;
         IData      <= '0;
         DDataReady <= 1'b0;
         DRData     <= '0;
         Err        <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_d     <= 1'b0;
`endif
      end else begin
         MemExecute <= 1'b0;
         IDataReady <= 1'b0;
         DDataReady <= 1'b0;
         Err        <= 1'b0;

         if (IReq && !i_pending) begin
            i_pending <= 1'b1;
            i_addr_q  <= IAddr;
         end
         if (DReq && !d_pending) begin
            d_pending <= 1'b1;
            d_addr_q  <= DAddr;
            d_we_q    <= DWe;
            d_wdata_q <= DWData;
            d_be_q    <= DBe;
         end

         case (state)
            ST_IDLE: begin
               if (MemReady && (i_cand || d_cand)) begin
                  state      <= ST_ISSUE;
                  MemExecute <= 1'b1;
                  if (pick_d) begin
                     MemWe    <= d_we_sel;
                     MemAddr  <= d_addr_sel;
                     MemWData <= d_wdata_sel;
                     MemBe    <= d_be_sel;
                     Grant    <= 2'b10;
                  end else begin
                     MemWe    <= 1'b0;
                     MemAddr  <= i_addr_sel;
                     MemWData <= '0;
                     MemBe    <= 4'hF;
                     Grant    <= 2'b01;
                  end
`ifdef MEM_ARB_RR_EN
                  last_d <= pick_d;
`endif
               end
            end
            ST_ISSUE: begin
               // Only a data-side store has MemWe set; it finishes here.
               if (MemWe) begin
                  d_pending <= 1'b0;
                  Grant     <= '0;
                  state     <= ST_IDLE;
               end else begin
                  cnt   <= '0;
                  state <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (rd_finish) begin
                  if (Grant[1]) begin
                     DRData     <= rd_data;
                     DDataReady <= 1'b1;
                     d_pending  <= 1'b0;
                  end else begin
                     IData      <= rd_data;
                     IDataReady <= 1'b1;
                     i_pending  <= 1'b0;
                  end
                  Err   <= ~MemDataReady;
                  Grant <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               Grant <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timestamp reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 8;

   logic        Clk;
   logic        Reset;
   logic        IReq;
   logic [31:0] IAddr;
   logic        IReady;
   logic        IDataReady;
   logic [31:0] IData;
   logic        DReq;
   logic        DWe;
   logic [31:0] DAddr;
   logic [31:0] DWData;
   logic [3:0]  DBe;
   logic        DReady;
   logic        DDataReady;
   logic [31:0] DRData;
   logic        MemExecute;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [3:0]  MemBe;
   logic        MemReady;
   logic        MemDataReady;
   logic [31:0] MemRData;
   logic [1:0]  Grant;
   logic        Err;
   logic [1:0]  dbg_state;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
      .Clk(Clk), .Reset(Reset),
      .IReq(IReq), .IAddr(IAddr), .IReady(IReady), .IDataReady(IDataReady), .IData(IData),
      .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DBe(DBe),
      .DReady(DReady), .DDataReady(DDataReady), .DRData(DRData),
      .MemExecute(MemExecute), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemBe(MemBe), .MemReady(MemReady), .MemDataReady(MemDataReady), .MemRData(MemRData),
      .Grant(Grant), .Err(Err), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   int cyc = 0;
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return 32'hC0DE0000 | {16'h0000, a[15:0]};
   endfunction

   // ---------------- memory responder ----------------
   int          rsp_delay = 0;
   int          rcnt = 0;
   logic [31:0] rdata = '0;
   initial begin
      MemDataReady = 1'b0;
      MemRData     = '0;
      forever begin
         @(posedge Clk);
         #1;
         MemDataReady = 1'b0;
         if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
               MemDataReady = 1'b1;
               MemRData     = rdata;
            end
         end
         if (MemExecute && !MemWe && rsp_delay > 0) begin
            rcnt  = rsp_delay;
            rdata = mem_word(MemAddr);
         end
      end
   end

   // ---------------- reference model ----------------
   bit          m_pi, m_pd, m_dwe, m_busy, m_own_d, m_store, m_last_d;
   logic [31:0] m_iaddr, m_daddr, m_dwdata;
   logic [3:0]  m_dbe;
   int          m_issue;
   logic        e_exec, e_we, e_idr, e_ddr, e_err;
   logic [31:0] e_addr, e_wdata, e_idata, e_drdata;
   logic [3:0]  e_be;
   logic [1:0]  e_grant;

   task model_reset();
      m_pi = 0; m_pd = 0; m_busy = 0; m_last_d = 0;
      e_exec = 0; e_we = 0; e_idr = 0; e_ddr = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_be = '0; e_grant = '0;
      e_idata = '0; e_drdata = '0;
   endtask

   // Computes the outputs for cycle n+1 from the inputs seen in cycle n.
   task model_step(input int n);
      bit pi0, pd0, ic, dc, take_d, fin;
      logic [31:0] data;
      pi0 = m_pi; pd0 = m_pd; fin = 0;
      e_exec = 0; e_idr = 0; e_ddr = 0; e_err = 0;
      if (m_busy) begin
         if (m_store) begin
            if (n == m_issue) fin = 1;
         end else if (n > m_issue && (MemDataReady || n == m_issue + TIMEOUT - 1)) begin
            fin   = 1;
            data  = MemDataReady ? MemRData : 32'h0;
            e_err = !MemDataReady;
            if (m_own_d) begin e_ddr = 1; e_drdata = data; end
            else         begin e_idr = 1; e_idata  = data; end
         end
      end
      if (IReq && !pi0) begin m_pi = 1; m_iaddr = IAddr; end
      if (DReq && !pd0) begin
         m_pd = 1; m_daddr = DAddr; m_dwe = DWe; m_dwdata = DWData; m_dbe = DBe;
      end
      if (!m_busy) begin
         ic = pi0 | IReq;
         dc = pd0 | DReq;
         if (MemReady && (ic || dc)) begin
`ifdef MEM_ARB_RR_EN
            take_d = dc && !(ic && m_last_d);
`else
            take_d = dc;
`endif
            m_busy = 1; m_issue = n + 1; m_own_d = take_d; m_last_d = take_d;
            m_store = take_d && m_dwe;
            e_exec  = 1;
            e_grant = take_d ? 2'b10 : 2'b01;
            e_we    = take_d ? m_dwe : 1'b0;
            e_addr  = take_d ? m_daddr : m_iaddr;
            if (take_d) begin e_wdata = m_dwdata; e_be = m_dbe; end
         end
      end
      if (fin) begin
         m_busy  = 0;
         e_grant = '0;
         if (m_own_d) m_pd = 0; else m_pi = 0;
      end
   endtask

   // ---------------- scoreboard / compare ----------------
   logic [31:0] exp_q[$];
   logic [1:0]  grant_log[$];
   bit          track = 0;
   int n_exec = 0, n_idr = 0, n_ddr = 0, n_err = 0;
   int exec_cyc = -1, idr_cyc = -1, ddr_cyc = -1, err_cyc = -1;
   logic        exec_we;
   logic [31:0] exec_addr, exec_wdata;
   logic [3:0]  exec_be;

   always @(negedge Clk) begin
      int n;
      n = cyc;
      if (Reset) model_reset();
      chk("mem_execute", MemExecute, e_exec);
      chk("grant", Grant, e_grant);
      chk("mem_we", MemWe, e_we);
      chk("mem_addr", MemAddr, e_addr);
      if (e_grant == 2'b10) begin
         chk("mem_wdata", MemWData, e_wdata);
         chk("mem_be", MemBe, e_be);
      end
      chk("i_ready", IReady, !m_pi);
      chk("d_ready", DReady, !m_pd);
      chk("i_data_ready", IDataReady, e_idr);
      chk("d_data_ready", DDataReady, e_ddr);
      chk("err", Err, e_err);
      chk("i_data", IData, e_idata);
      chk("d_rdata", DRData, e_drdata);
      if (MemExecute) begin
         n_exec++; exec_cyc = n; grant_log.push_back(Grant);
         exec_we = MemWe; exec_addr = MemAddr; exec_wdata = MemWData; exec_be = MemBe;
         if (track) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL exec_addr: got unexpected issue to %h, expected none", MemAddr);
            end else chk("exec_addr", MemAddr, exp_q.pop_front());
         end
      end
      if (IDataReady) begin n_idr++; idr_cyc = n; end
      if (DDataReady) begin n_ddr++; ddr_cyc = n; end
      if (Err)        begin n_err++; err_cyc = n; end
      if (!Reset) model_step(n);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      tick();
   endtask

   // ---------------- directed tests ----------------
   int r, k0, k1;
   localparam int NV = 16;
   logic [3:0] vec[NV] = '{4'b1001, 4'b1010, 4'b1111, 4'b0011, 4'b0001, 4'b1000, 4'b1110, 4'b1011,
                           4'b0110, 4'b1001, 4'b1001, 4'b1000, 4'b1010, 4'b1101, 4'b0000, 4'b1011};

   initial begin
      Reset = 1'b1;
      IReq = 0; IAddr = '0; DReq = 0; DWe = 0; DAddr = '0; DWData = '0; DBe = '0; MemReady = 1'b1;
      tick(); tick();
      Reset = 1'b0;
      tick();
      chk("rst_i_ready", IReady, 1'b1);
      chk("rst_d_ready", DReady, 1'b1);
      chk("rst_grant", Grant, 2'b00);
      chk("rst_mem_execute", MemExecute, 1'b0);
      track = 1;

      // single fetch, data returned 3 cycles after MemExecute
      rsp_delay = 3; k0 = n_exec; k1 = n_idr;
      exp_q.push_back(32'h100);
      IReq = 1; IAddr = 32'h100; r = cyc; tick(); IReq = 0;
      chk("fetch_i_ready_low", IReady, 1'b0);
      repeat (8) tick();
      chk("fetch_exec_cycle", exec_cyc, r + 1);
      chk("fetch_exec_count", n_exec - k0, 1);
      chk("fetch_exec_we", exec_we, 1'b0);
      chk("fetch_idr_cycle", idr_cyc, r + 5);
      chk("fetch_idr_count", n_idr - k1, 1);
      chk("fetch_idata", IData, 32'hDEADBEEF);

      // store
      k0 = n_exec; k1 = n_ddr;
      exp_q.push_back(32'h2004);
      DReq = 1; DWe = 1; DAddr = 32'h2004; DWData = 32'h12345678; DBe = 4'b1100; r = cyc;
      tick(); DReq = 0; DWe = 0;
      chk("store_d_ready_low", DReady, 1'b0);
      tick();
      chk("store_d_ready_back", DReady, 1'b1);
      repeat (3) tick();
      chk("store_exec_cycle", exec_cyc, r + 1);
      chk("store_exec_count", n_exec - k0, 1);
      chk("store_we", exec_we, 1'b1);
      chk("store_wdata", exec_wdata, 32'h12345678);
      chk("store_be", exec_be, 4'b1100);
      chk("store_no_ddr", n_ddr - k1, 0);

      // collision from a fresh reset
      do_reset();
      grant_log.delete();
      rsp_delay = 2;
      exp_q.push_back(32'h40); exp_q.push_back(32'h80);
      IReq = 1; IAddr = 32'h80; DReq = 1; DWe = 0; DAddr = 32'h40; r = cyc;
      tick(); IReq = 0; DReq = 0;
      repeat (12) tick();
      chk("coll_grant0", grant_log[0], 2'b10);
      chk("coll_grant1", grant_log[1], 2'b01);
      chk("coll_second_exec", exec_cyc, r + 5);
      chk("coll_drdata", DRData, 32'hC0DE0040);
      chk("coll_idata", IData, 32'hC0DE0080);

      // read timeout
      rsp_delay = 0; k0 = n_err;
      exp_q.push_back(32'h300);
      DReq = 1; DWe = 0; DAddr = 32'h300; r = cyc;
      tick(); DReq = 0;
      repeat (12) tick();
      chk("tmo_err_cycle", err_cyc, r + 1 + TIMEOUT);
      chk("tmo_ddr_cycle", ddr_cyc, r + 1 + TIMEOUT);
      chk("tmo_err_count", n_err - k0, 1);
      chk("tmo_drdata", DRData, 32'h0);
      chk("tmo_idle_grant", Grant, 2'b00);

      // MemReady held low for 5 cycles
      rsp_delay = 1; k0 = n_exec;
      exp_q.push_back(32'h500);
      MemReady = 0; IReq = 1; IAddr = 32'h500; r = cyc;
      tick(); IReq = 0;
      repeat (4) tick();
      chk("stall_no_exec", n_exec - k0, 0);
      MemReady = 1;
      repeat (4) tick();
      chk("stall_exec_cycle", exec_cyc, r + 6);

      // reset during RD_WAIT, then a late data pulse
      rsp_delay = 4; k1 = n_idr;
      exp_q.push_back(32'h600);
      IReq = 1; IAddr = 32'h600; r = cyc;
      tick(); IReq = 0;
      tick(); tick();
      k0 = n_exec;
      Reset = 1; #1;
      chk("mid_rst_i_ready", IReady, 1'b1);
      chk("mid_rst_d_ready", DReady, 1'b1);
      chk("mid_rst_grant", Grant, 2'b00);
      chk("mid_rst_addr", MemAddr, 32'h0);
      tick(); Reset = 0;
      repeat (4) tick();
      chk("late_mdr_no_idr", n_idr - k1, 0);
      chk("late_mdr_no_exec", n_exec - k0, 0);

      // completion handoff: new fetch in the IDataReady cycle
      rsp_delay = 2;
      exp_q.push_back(32'h800); exp_q.push_back(32'h804);
      IReq = 1; IAddr = 32'h800; r = cyc;
      tick(); IReq = 0;
      repeat (3) tick();
      chk("handoff_idr_now", IDataReady, 1'b1);
      IReq = 1; IAddr = 32'h804;
      tick(); IReq = 0;
      repeat (5) tick();
      chk("handoff_exec_cycle", exec_cyc - 5, r);
      chk("handoff_idata", IData, 32'hC0DE0804);

      // directed vector table, model-checked
      track = 0; rsp_delay = 1;
      for (int i = 0; i < NV; i++) begin
         {MemReady, DWe, DReq, IReq} = vec[i];
         IAddr = 32'h1000 + 32'(i * 4); DAddr = 32'h2000 + 32'(i * 4);
         DWData = 32'hA0000000 + 32'(i); DBe = 4'(i);
         tick();
      end
      IReq = 0; DReq = 0; DWe = 0; MemReady = 1;
      repeat (12) tick();

      // continuous requests from both sides
      do_reset();
      grant_log.delete();
      for (int i = 0; i < 40; i++) begin
         IReq = 1; IAddr = 32'h700; DReq = 1; DWe = 1; DAddr = 32'h3000; DWData = 32'(i); DBe = 4'hF;
         tick();
      end
      IReq = 0; DReq = 0; DWe = 0;
      repeat (12) tick();
`ifdef MEM_ARB_RR_EN
      chk("rr_grant0", grant_log[0], 2'b10);
      chk("rr_grant1", grant_log[1], 2'b01);
      chk("rr_grant2", grant_log[2], 2'b10);
      chk("rr_grant3", grant_log[3], 2'b01);
`else
      chk("fixed_grant0", grant_log[0], 2'b10);
      chk("fixed_grant1", grant_log[1], 2'b10);
      chk("fixed_grant2", grant_log[2], 2'b10);
      chk("fixed_grant3", grant_log[3], 2'b10);
`endif

      chk("exp_q_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester and the load/store requester of the control unit.
- Latches one-cycle request pulses and arbitrates between them. Issues one memory transaction at a time, returns read data to the owning requester, and guards reads with a timeout.
- Sits between the core control/datapath and the memory/bus interface.

Parameters:
- TIMEOUT, 64: cycles to wait for MemDataReady on a read before forcing completion with an error; must be ≥2.
- ADDR_W, 32: address width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IReq  in  1  fetch request pulse; always a read.
- IAddr  in  ADDR_W  fetch address, sampled when IReq=1.
- IReady  out  1  fetch side may issue; =~iPending.
- IDataReady  out  1  one-cycle pulse: IData valid.
- IData  out  32  fetch read data; held until the next fetch completion.
- DReq  in  1  data request pulse.
- DWe  in  1  1=store, 0=load; sampled with DReq.
- DAddr  in  ADDR_W  data address, sampled with DReq.
- DWData  in  32  store data, sampled with DReq.
- DBe  in  4  byte enables, sampled with DReq.
- DReady  out  1  data side may issue; =~dPending.
- DDataReady  out  1  one-cycle pulse: DRData valid (loads only).
- DRData  out  32  load data; held until the next load completion.
- MemExecute  out  1  one-cycle transaction strobe to memory.
- MemWe, MemAddr, MemWData, MemBe  out  1/ADDR_W/32/4  registered transaction fields, stable from MemExecute until the next issue.
- MemReady  in  1  memory can accept a transaction.
- MemDataReady  in  1  read data valid pulse.
- MemRData  in  32  read data.
- Grant  out  2  one-hot owner of the in-flight transaction: bit0=I, bit1=D; 0 when idle.
- Err  out  1  one-cycle pulse on read timeout.

Behaviour:
- Reset (async): state=IDLE; both pending flags clear. All outputs 0 except IReady=DReady=1.
- Capture:
  - IReq/DReq with the matching pending flag clear sets that flag and latches the fields.
  - A request while its flag is already set is ignored; the latched fields are not overwritten.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - Arbitration candidates are the pending flags OR'd with same-cycle request pulses (bypass). A request arriving while IDLE with MemReady=1 therefore gives MemExecute=1 in the next cycle.
  - If MemReady=1 and any candidate exists: pick the winner (D over I); drive Mem* fields from the winner; set MemExecute=1 and Grant; go to ISSUE.
  - If MemReady=0: stay in IDLE; requests remain pending.
- ISSUE (exactly 1 cycle, MemExecute=1):
  - Next cycle MemExecute=0.
  - Store: clear dPending; Grant=0; go to IDLE. A store produces no DDataReady.
  - Read: clear the timeout counter; go to RD_WAIT.
- RD_WAIT:
  - On MemDataReady=1: register MemRData into IData or DRData per Grant; pulse the matching *DataReady in the next cycle; clear that pending flag; Grant=0; go to IDLE.
  - Otherwise increment the counter. When it reaches TIMEOUT-1, complete as above with data 32'h00000000 and pulse Err with the same timing.
  - MemDataReady in IDLE/ISSUE is ignored.
- Completion handoff: the pending flag clears on the same edge the DataReady pulse is registered. A new request from the same side is accepted in the cycle IDataReady/DDataReady is high.
- Back-to-back: the minimum gap between consecutive MemExecute pulses is 2 cycles for stores. For reads it is 1 cycle after data return.
- Simultaneous IReq+DReq: both captured; D served first, I on the following IDLE arbitration.
- Reset mid-transaction: all flags and outputs clear immediately. A late MemDataReady after reset is ignored.

Optional Feature:
- MEM_ARB_RR_EN:
  - Defined: a 1-bit last-grant register (reset = I) makes arbitration round-robin when both sides are pending; the side not last granted wins. Single-candidate behaviour is unchanged.
  - Undefined: fixed priority D over I; fetch can starve under a continuous data stream.

Test Plan:
- Single fetch: IReq, IAddr=0x100, MemReady=1, memory returns 0xDEADBEEF 3 cycles after MemExecute → exactly one MemExecute with MemAddr=0x100, MemWe=0; IDataReady pulse with IData=0xDEADBEEF; IReady low until then.
- Store: DReq, DWe=1, DAddr=0x2004, DWData=0x12345678, DBe=4'b1100 → one MemExecute with those fields; no DDataReady; DReady high 2 cycles after DReq.
- Collision: IReq+DReq same cycle (DWe=0, DAddr=0x40; IAddr=0x80) → first MemAddr=0x40, Grant=2'b10; second MemAddr=0x80 after the D completion; DRData and IData routed correctly.
- Timeout: load to 0x300, MemDataReady never asserted, TIMEOUT=8 → Err and DDataReady pulse together 8 cycles after ISSUE; DRData=0; arbiter returns to IDLE.
- MemReady=0 for 5 cycles with IReq pending → no MemExecute; issue occurs in the cycle after MemReady rises.
- Reset asserted during RD_WAIT → all outputs 0 asynchronously, IReady=DReady=1; a MemDataReady pulse afterward produces no *DataReady. With MEM_ARB_RR_EN, continuous IReq+DReq requests alternate grants D, I, D, I.
